uart_cmd_rx: RTL and testbench
==============================

# uart_cmd_rx

Serial command receiver on the robot side of the command link. Samples the asynchronous UART line driven by the command master and recovers 8N1 bytes. Pairs each two consecutive bytes into a 16-bit travel-plan command word, and presents that word with a sticky ready flag to the command processor. Sits directly downstream of the command master's TX pin and directly upstream of the command-processing logic inside the maze runner.

## Interface
- BAUD_DIV, 2604, clk cycles per bit (19200 baud at 50 MHz); must be ≥ 16.
- BYTE_TO, 65536, max clk cycles allowed from end of high byte to start of low byte.

- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- RX  in  1  serial line from command master; idles high; asynchronous to clk.
- clr_cmd_rdy  in  1  consumer acknowledge; clears cmd_rdy.
- cmd  out  16  last complete command; high byte received first.
- cmd_rdy  out  1  new cmd available; sticky.
- frm_err  out  1  one-cycle pulse on a bad stop bit or an inter-byte timeout.

## Operation
- RX passes through a 2-flop synchronizer; both flops reset to 1.
- The bit FSM uses the synchronized line (rx_s).
- **IDLE**: wait for rx_s falling (prev 1, now 0).
  - On the edge: load bit counter with BAUD_DIV/2 (floor), go to START.
- **START**: at counter expiry, sample rx_s.
  - 1: false start; return to IDLE, no error.
  - 0: reload BAUD_DIV, bit index = 0, go to DATA.
- **DATA**: sample at each expiry and shift in LSB first into an 8-bit shift register.
  - After index 7, reload BAUD_DIV and go to STOP.
- **STOP**: sample at expiry.
  - 1: byte valid.
  - 0: frm_err pulse, byte dropped, assembly FSM forced to HIGH.
  - Either case returns to IDLE.
- Assembly FSM:
  - **HIGH**: a valid byte is stored to the high-byte holding register; start the timeout counter; go to LOW.
  - **LOW**: a valid byte writes cmd = {held_high, byte} and sets cmd_rdy; go to HIGH.
  - **LOW timeout**: if the counter reaches BYTE_TO before a START is entered, frm_err pulse, discard the held byte, go to HIGH.
- cmd_rdy handling:
  - Set on a cmd write.
  - Cleared by clr_cmd_rdy.
  - Also cleared on a false→true transition from IDLE into START while in assembly state HIGH (a new command begins, so the old cmd becomes stale).
- cmd changes only on a completed pair; a partial or errored frame never disturbs cmd.
- Reset values:
  - cmd = 0x0000, cmd_rdy = 0, frm_err = 0.
  - FSMs in IDLE/HIGH, all counters 0.

## Timing
- Define t0 = the cycle rx_s is first seen low. Samples occur at:
  - start bit: t0 + BAUD_DIV/2
  - data bit k: t0 + BAUD_DIV/2 + (k+1)·BAUD_DIV
  - stop bit: t0 + BAUD_DIV/2 + 9·BAUD_DIV
- Synchronizer adds 2 cycles between an RX edge and t0.
- cmd and cmd_rdy update on the clock edge after the low-byte stop sample (registered).
- frm_err is asserted for exactly 1 cycle, on the cycle after the failing stop sample or the timeout expiry.
- Simultaneous clr_cmd_rdy and cmd write in the same cycle: set wins, cmd_rdy = 1.
- A stop-bit sample and an immediate new falling edge are legal. IDLE is re-entered on the stop sample cycle, so back-to-back frames with zero idle are accepted.
- Bit counter width is ceil(log2(BAUD_DIV+1)); timeout counter width is ceil(log2(BYTE_TO+1)). Neither counter wraps; both are held at terminal value until reloaded.
- Reset asserted mid-frame: all state is cleared immediately. The partial frame is lost, and cmd and cmd_rdy return to reset values.

## Test plan
- **Nominal command**: with BAUD_DIV=2604, drive frames 0x00 then 0x03 → cmd=0x0003, cmd_rdy rises 1 cycle after the second stop sample; clr_cmd_rdy pulse → cmd_rdy=0 next cycle, cmd holds 0x0003.
- **Glitch rejection**: RX low for 1000 cycles, then high → no sample accepted, frm_err=0, FSM back in IDLE; a following pair 0xA5, 0x5A → cmd=0xA55A.
- **Framing error**: second byte sent with stop bit 0 → frm_err single-cycle pulse, cmd unchanged, cmd_rdy stays 0; next pair 0x12, 0x34 → cmd=0x1234.
- **Inter-byte timeout**: send 0x00, idle > BYTE_TO cycles, then send 0x01, 0x0D → frm_err pulse at timeout, final cmd=0x010D (0x01 treated as the high byte).
- **Set/clear collision**: assert clr_cmd_rdy in the exact cycle cmd is written → cmd_rdy=1. Also, back-to-back frames with zero idle bits are received correctly.
- **Mid-frame reset**: pulse rst during the data bit 4 of a low byte → cmd=0, cmd_rdy=0 immediately; a subsequent full pair is received correctly.

Source files
------------

// File: rtl/uart_cmd_rx_if.sv
// Command-link bundle between the UART command receiver and its consumer.
// The master drives the serial line and the ack; the slave returns the command.
interface uart_cmd_rx_if;
  logic        RX;
  logic        clr_cmd_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        frm_err;

  modport master (
    output RX,
    output clr_cmd_rdy,
    input  cmd,
    input  cmd_rdy,
    input  frm_err
  );

  modport slave (
    input  RX,
    input  clr_cmd_rdy,
    output cmd,
    output cmd_rdy,
    output frm_err
  );
endinterface

// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver that pairs bytes into 16-bit travel-plan commands.
// High byte first; a sticky ready flag marks each new command.
module uart_cmd_rx #(
  parameter int BAUD_DIV = 2604,
  parameter int BYTE_TO  = 65536
) (
  input logic          clk,
  input logic          rst,
  uart_cmd_rx_if.slave bus
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam int TW = $clog2(BYTE_TO + 1);

  localparam logic [CW-1:0] HALF   = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0] FULL   = CW'(BAUD_DIV);
  localparam logic [TW-1:0] TO_MAX = TW'(BYTE_TO);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } bit_st_e;

  typedef enum logic {
    A_HIGH,
    A_LOW
  } asm_st_e;

  bit_st_e       st_q, st_d;
  asm_st_e       asm_q, asm_d;
  logic          sync_q, rxs_q, rxp_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    hold_q, hold_d;
  logic [TW-1:0] to_q, to_d;
  logic [15:0]   cmd_q, cmd_d;
  logic          rdy_q, rdy_d;
  logic          err_q, err_d;

  logic tick, fall, start_go;
  logic stop_ok, stop_bad, timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= S_IDLE;
      asm_q  <= A_HIGH;
      sync_q <= 1'b1;
      rxs_q  <= 1'b1;
      rxp_q  <= 1'b1;
      cnt_q  <= '0;
      idx_q  <= '0;
      sh_q   <= '0;
      hold_q <= '0;
      to_q   <= '0;
      cmd_q  <= '0;
      rdy_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      asm_q  <= asm_d;
      sync_q <= bus.RX;
      rxs_q  <= sync_q;
      rxp_q  <= rxs_q;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      sh_q   <= sh_d;
      hold_q <= hold_d;
      to_q   <= to_d;
      cmd_q  <= cmd_d;
      rdy_q  <= rdy_d;
      err_q  <= err_d;
    end
  end

  // Strobes decoded from the current state
  always_comb begin
    tick     = (cnt_q == CW'(1));
    fall     = rxp_q && !rxs_q;
    start_go = (st_q == S_IDLE) && fall;
    stop_ok  = (st_q == S_STOP) && tick && rxs_q;
    stop_bad = (st_q == S_STOP) && tick && !rxs_q;
    timeout  = (asm_q == A_LOW) && (st_q == S_IDLE)
            && !fall && (to_q == TO_MAX);
  end

  always_comb begin
    st_d  = st_q;
    idx_d = idx_q;
    sh_d  = sh_q;
    cnt_d = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    unique case (st_q)
      S_IDLE: begin
        if (fall) begin
          st_d  = S_START;
          cnt_d = HALF;
        end
      end
      S_START: begin
        if (tick) begin
          if (rxs_q) begin
            st_d = S_IDLE;
          end else begin
            st_d  = S_DATA;
            cnt_d = FULL;
            idx_d = '0;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          sh_d  = {rxs_q, sh_q[7:1]};
          cnt_d = FULL;
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) st_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) st_d = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
  end

  // Byte pairing; the gap timer only runs while the line is idle
  always_comb begin
    asm_d  = asm_q;
    hold_d = hold_q;
    cmd_d  = cmd_q;
    to_d   = to_q;
    rdy_d  = rdy_q;
    err_d  = stop_bad || timeout;
    if (asm_q == A_LOW && st_q == S_IDLE && to_q != TO_MAX)
      to_d = to_q + TW'(1);
    if (bus.clr_cmd_rdy || (start_go && asm_q == A_HIGH))
      rdy_d = 1'b0;
    unique case (asm_q)
      A_HIGH: begin
        if (stop_ok) begin
          hold_d = sh_q;
          to_d   = '0;
          asm_d  = A_LOW;
        end
      end
      A_LOW: begin
        if (stop_ok) begin
          cmd_d = {hold_q, sh_q};
          rdy_d = 1'b1;
          asm_d = A_HIGH;
        end else if (stop_bad || timeout) begin
          hold_d = '0;
          asm_d  = A_HIGH;
        end
      end
      default: asm_d = A_HIGH;
    endcase
  end

  assign bus.cmd     = cmd_q;
  assign bus.cmd_rdy = rdy_q;
  assign bus.frm_err = err_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed plus randomized bench for the UART command receiver.
// Expected commands come from a byte-pairing model driven by what is sent.
module tb_uart_cmd_rx;

  localparam int BD = 20;
  localparam int TO = 600;
  localparam int H  = BD / 2;
  localparam int T_OLD = 2 + H + 9 * BD;
  localparam int T_NEW = T_OLD + 1;

  logic clk;
  logic rst;
  uart_cmd_rx_if bif();

  uart_cmd_rx #(
    .BAUD_DIV(BD),
    .BYTE_TO (TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int err_cyc = 0;

  always @(negedge clk) if (bif.frm_err === 1'b1) err_cyc++;

  // Byte-pair reference model
  bit          have_hi;
  logic [7:0]  hi_b;
  logic [15:0] m_cmd;
  logic        m_rdy;
  int          m_err;

  function automatic void m_reset();
    have_hi = 0;
    hi_b    = '0;
    m_cmd   = '0;
    m_rdy   = 1'b0;
  endfunction

  function automatic void m_start();
    if (!have_hi) m_rdy = 1'b0;
  endfunction

  function automatic void m_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      have_hi = 0;
      m_err++;
    end else if (!have_hi) begin
      have_hi = 1;
      hi_b    = b;
    end else begin
      m_cmd   = {hi_b, b};
      m_rdy   = 1'b1;
      have_hi = 0;
    end
  endfunction

  function automatic void m_timeout();
    if (have_hi) begin
      have_hi = 0;
      m_err++;
    end
  endfunction

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_cmd"}, bif.cmd, m_cmd);
    chk({tag, "_rdy"}, 16'(bif.cmd_rdy), 16'(m_rdy));
    chk({tag, "_err"}, 16'(err_cyc), 16'(m_err));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input bit stop,
                      input bit clr_hit, input int abort);
    logic [9:0] fr;
    bit lowb;
    fr   = {stop, b, 1'b0};
    lowb = have_hi && stop;
    m_start();
    for (int n = 0; n < 10 * BD; n++) begin
      if (n == abort) begin
        rst = 1'b1;
        #1;
        m_reset();
        chk("rst_cmd", bif.cmd, 16'h0000);
        chk("rst_rdy", 16'(bif.cmd_rdy), 16'h0000);
        @(negedge clk);
        rst    = 1'b0;
        bif.RX = 1'b1;
        return;
      end
      bif.RX = fr[4'(n / BD)];
      @(negedge clk);
      if (lowb && n + 1 == T_OLD) begin
        chk("rdy_before", 16'(bif.cmd_rdy), 16'(m_rdy));
        if (clr_hit) bif.clr_cmd_rdy = 1'b1;
      end
      if (lowb && n + 1 == T_NEW) begin
        bif.clr_cmd_rdy = 1'b0;
        chk("cmd_edge", bif.cmd, {hi_b, b});
        chk("rdy_edge", 16'(bif.cmd_rdy), 16'h0001);
      end
    end
    bif.RX = 1'b1;
    m_byte(b, stop);
  endtask

  task automatic pulse_clr();
    bif.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    bif.clr_cmd_rdy = 1'b0;
    m_rdy = 1'b0;
  endtask

  task automatic glitch();
    m_start();
    bif.RX = 1'b0;
    idle(BD / 4);
    bif.RX = 1'b1;
    idle(BD);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a, c;
    bit bad;
    m_reset();
    m_err           = 0;
    rst             = 1'b1;
    bif.RX          = 1'b1;
    bif.clr_cmd_rdy = 1'b0;
    idle(3);
    chk_all("reset");
    rst = 1'b0;
    idle(5);

    send(8'h00, 1, 0, -1);
    send(8'h03, 1, 0, -1);
    idle(4);
    chk_all("nominal");
    pulse_clr();
    chk_all("clr");

    glitch();
    chk_all("glitch");
    send(8'hA5, 1, 0, -1);
    idle(7);
    send(8'h5A, 1, 0, -1);
    idle(3);
    chk_all("glitch_pair");

    send(8'h77, 1, 0, -1);
    send(8'h88, 0, 0, -1);
    idle(BD + 5);
    chk_all("framing");
    send(8'h12, 1, 0, -1);
    send(8'h34, 1, 0, -1);
    idle(2);
    chk_all("after_framing");

    send(8'h00, 1, 0, -1);
    idle(TO + 100);
    m_timeout();
    chk_all("timeout");
    send(8'h01, 1, 0, -1);
    send(8'h0D, 1, 0, -1);
    idle(2);
    chk_all("after_timeout");

    a = 8'($urandom);
    c = 8'($urandom);
    send(a, 1, 0, -1);
    send(c, 1, 1, -1);
    idle(2);
    chk_all("collision");
    for (int i = 0; i < 4; i++) send(8'($urandom), 1, 0, -1);
    idle(2);
    chk_all("back2back");

    send(8'hC3, 1, 0, -1);
    send(8'h3C, 1, 0, 5 * BD + BD / 2);
    idle(10);
    chk_all("mid_reset");
    send(8'h9E, 1, 0, -1);
    send(8'h61, 1, 0, -1);
    idle(2);
    chk_all("after_reset");

    for (int i = 0; i < 10; i++) begin
      a   = 8'($urandom);
      c   = 8'($urandom);
      bad = ($urandom_range(0, 4) == 0);
      send(a, 1, 0, -1);
      idle($urandom_range(0, 25));
      send(c, !bad, 0, -1);
      idle(bad ? BD + 3 : $urandom_range(0, 25));
      chk_all("rand");
      if ($urandom_range(0, 2) == 0) begin
        pulse_clr();
        chk_all("rand_clr");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
